if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage and IF/ID pipeline register; the consumer of the stall/refresh controls from the pipeline control unit.
//  Generates the next PC, drives the 1-cycle-latency instruction SRAM, and holds fetched data in a one-entry buffer while stalled.
//  Redirects on exception or taken branch and presents {id_pc, id_inst} to ID, with id_pc==0 marking a bubble.
// PARAMETERS
//  RESET_PC  32'hBFC0_0000  first fetch address after reset
//  XLEN      32             PC / instruction width
// PORTS
//  clk              in   1     single clock, all state on posedge
//  rst              in   1     synchronous reset, active-high
//  if_id_stall      in   1     hold IF and the IF/ID register
//  if_id_refresh    in   1     exception flush of IF and IF/ID; overrides stall
//  exc_pc           in   32    exception/ERET target, used when if_id_refresh=1
//  id_br_taken      in   1     taken branch/jump resolved in ID
//  id_br_target     in   32    branch/jump target
//  inst_sram_en     out  1     SRAM read request
//  inst_sram_addr   out  32    SRAM read address (= npc)
//  inst_sram_rdata  in   32    SRAM data, valid the cycle after the request
//  id_pc            out  32    PC of the instruction in ID; 0 = bubble
//  id_inst          out  32    instruction in ID; 0 (nop) on bubble
//  id_adel          out  1     fetch address error (id_pc[1:0]!=0)
// BEHAVIOUR
//  State: pc_f (address of the data returning this cycle), f_valid, buf_valid, buf_inst, plus the IF/ID register.
//  Reset: pc_f=RESET_PC-4, f_valid=0, buf_valid=0, id_pc=0, id_inst=0, id_adel=0; inst_sram_en=0 while rst=1.
//  npc priority: refresh ? exc_pc : stall ? pc_f : id_br_taken ? id_br_target : pc_f+4 (modulo 2^32).
//  A branch is accepted only when !stall, because a stalled ID keeps the branch and re-presents it.
//  Delay slot: the branch's slot is the instruction already in IF, so only the following fetch is redirected.
//  inst_sram_en = !rst && !(if_id_stall && !if_id_refresh); the SRAM is not read while stalled.
//  Each non-stalled cycle: pc_f<=npc, f_valid<=1.
//  Fetched word: fdata = buf_valid ? buf_inst : inst_sram_rdata.
//  Stall cycle, f_valid=1 and buf_valid=0: buf_inst<=inst_sram_rdata, buf_valid<=1 (captured exactly once per stall).
//  First non-stalled cycle: IF/ID <= {pc_f, fdata, pc_f[1:0]!=0}; buf_valid<=0.
//  Stall, no refresh: IF/ID holds its value.
//  When f_valid=0, IF/ID loads the bubble {0,0,0}.
//  Refresh (any stall value): IF/ID <= bubble, buf_valid<=0, pc_f<=exc_pc, f_valid<=1; the next ID entry is exc_pc.
//  Address error: misaligned pc_f is still requested; id_inst=0 and id_adel=1 travel with it, and the SRAM data is ignored.
//  Latency: address issued in cycle t, data at IF in t+1, instruction in ID in t+2 when no stalls occur.
//  Reset asserted mid-operation takes precedence over all inputs and discards the buffer.
// STRUCTURE
//  Shared package: RESET_PC, EXC_ENTRY (32'hBFC0_0380), NOP_INST, BUBBLE_PC=0.
//  Sub-module fetch_hold_buf: one-entry capture/clear buffer (capture, clear, din -> valid, dout).
//  Top level: npc mux, pc_f/f_valid registers, IF/ID register.
// TESTING
//  Reset release with no stalls -> addr BFC00000, BFC00004, BFC00008 on consecutive cycles; id_pc=BFC00000 two cycles after release.
//  Stall held 3 cycles while the SRAM returns garbage after cycle 1 -> en=0 during the stall; after release, ID shows the word captured in cycle 1 at the correct pc.
//  Taken branch at 0x100 to 0x200 -> ID sequence 0x100, 0x104 (delay slot), 0x200.
//  Branch with stall -> redirect waits until the stall drops; no duplicate or skipped PC.
//  Refresh during stall with exc_pc=BFC00380 -> ID bubble (pc 0) next cycle, buffer cleared, then id_pc=BFC00380.
//  Jump to 0x202 -> id_pc=0x202, id_adel=1, id_inst=0.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage and its helpers.
package if_fetch_stage_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam logic [31:0] RESET_PC  = 32'hBFC0_0000;
    localparam logic [31:0] EXC_ENTRY = 32'hBFC0_0380;
    localparam logic [31:0] NOP_INST  = 32'h0000_0000;
    localparam logic [31:0] BUBBLE_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'h0000_0004;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry holding buffer: keeps a fetched word alive while the pipeline is stalled.
module fetch_hold_buf #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         capture,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic         valid,
    output logic [W-1:0] dout
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // Clear wins over capture so a refresh or resume always empties the entry.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d = 1'b1;
            data_d  = din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign dout  = data_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: next-PC selection, SRAM request, stall holding buffer and IF/ID register.
module if_fetch_stage #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(if_fetch_stage_pkg::RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_id_stall,
    input  logic            if_id_refresh,
    input  logic [XLEN-1:0] exc_pc,
    input  logic            id_br_taken,
    input  logic [XLEN-1:0] id_br_target,
    output logic            inst_sram_en,
    output logic [XLEN-1:0] inst_sram_addr,
    input  logic [XLEN-1:0] inst_sram_rdata,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_inst,
    output logic            id_adel
);

    import if_fetch_stage_pkg::*;

    logic [XLEN-1:0] pc_f_q, pc_f_d;
    logic            f_valid_q, f_valid_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic [XLEN-1:0] id_inst_q, id_inst_d;
    logic            id_adel_q, id_adel_d;

    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] fdata;
    logic [XLEN-1:0] buf_inst;
    logic            buf_valid;
    logic            buf_capture;
    logic            stall_eff;
    logic            f_adel;

    // Refresh overrides stall: a flush always moves the front end.
    assign stall_eff = if_id_stall && !if_id_refresh;

    // A stalled ID re-presents its branch, so redirect only when not stalled.
    always_comb begin
        npc = pc_f_q + XLEN'(PC_STEP);
        if (if_id_refresh) begin
            npc = exc_pc;
        end else if (if_id_stall) begin
            npc = pc_f_q;
        end else if (id_br_taken) begin
            npc = id_br_target;
        end
    end

    assign inst_sram_en   = !rst && !stall_eff;
    assign inst_sram_addr = npc;

    assign buf_capture = stall_eff && f_valid_q && !buf_valid;
    assign fdata       = buf_valid ? buf_inst : inst_sram_rdata;
    assign f_adel      = |pc_f_q[1:0];

    fetch_hold_buf #(
        .W (XLEN)
    ) u_hold_buf (
        .clk     (clk),
        .rst     (rst),
        .capture (buf_capture),
        .clear   (!stall_eff),
        .din     (inst_sram_rdata),
        .valid   (buf_valid),
        .dout    (buf_inst)
    );

    always_comb begin
        pc_f_d    = pc_f_q;
        f_valid_d = f_valid_q;
        id_pc_d   = id_pc_q;
        id_inst_d = id_inst_q;
        id_adel_d = id_adel_q;

        if (!stall_eff) begin
            pc_f_d    = npc;
            f_valid_d = 1'b1;
        end

        // Misaligned fetches carry a nop and the error flag instead of SRAM data.
        if (if_id_refresh || (!stall_eff && !f_valid_q)) begin
            id_pc_d   = XLEN'(BUBBLE_PC);
            id_inst_d = XLEN'(NOP_INST);
            id_adel_d = 1'b0;
        end else if (!stall_eff) begin
            id_pc_d   = pc_f_q;
            id_inst_d = f_adel ? XLEN'(NOP_INST) : fdata;
            id_adel_d = f_adel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f_q    <= RESET_PC - XLEN'(PC_STEP);
            f_valid_q <= 1'b0;
            id_pc_q   <= XLEN'(BUBBLE_PC);
            id_inst_q <= XLEN'(NOP_INST);
            id_adel_q <= 1'b0;
        end else begin
            pc_f_q    <= pc_f_d;
            f_valid_q <= f_valid_d;
            id_pc_q   <= id_pc_d;
            id_inst_q <= id_inst_d;
            id_adel_q <= id_adel_d;
        end
    end

    assign id_pc   = id_pc_q;
    assign id_inst = id_inst_q;
    assign id_adel = id_adel_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage with a 1-cycle-latency instruction SRAM model.
module tb_if_fetch_stage;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam logic [31:0] EXC_PC = 32'hBFC0_0380;
    localparam logic [31:0] MEM_K  = 32'hA5A5_5A5A;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_id_stall = 1'b0;
    logic        if_id_refresh = 1'b0;
    logic [31:0] exc_pc = '0;
    logic        id_br_taken = 1'b0;
    logic [31:0] id_br_target = '0;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata = 32'hDEAD_BEEF;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_adel;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    logic adv = 1'b0;

    if_fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .if_id_stall     (if_id_stall),
        .if_id_refresh   (if_id_refresh),
        .exc_pc          (exc_pc),
        .id_br_taken     (id_br_taken),
        .id_br_target    (id_br_target),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata),
        .id_pc           (id_pc),
        .id_inst         (id_inst),
        .id_adel         (id_adel)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ MEM_K;
    endfunction

    // SRAM: data one cycle after an enabled request, garbage when not read.
    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= mem_word(inst_sram_addr);
        else              inst_sram_rdata <= $urandom();
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    function automatic void push_bubble();
        exp_t e;
        e.pc = 32'h0; e.inst = 32'h0; e.adel = 1'b0;
        sb.push_back(e);
    endfunction

    function automatic void push_pc(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.adel = (pc[1:0] != 2'b00);
        e.inst = e.adel ? 32'h0 : mem_word(pc);
        sb.push_back(e);
    endfunction

    // An IF/ID update happens on every edge that is out of reset and not held by a plain stall.
    always @(posedge clk) adv <= !rst && (!if_id_stall || if_id_refresh);

    always @(negedge clk) begin
        if (adv) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_entry", id_pc, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("id_pc", id_pc, e.pc);
                check("id_inst", id_inst, e.inst);
                check("id_adel", 32'(id_adel), 32'(e.adel));
            end
        end
    end

    task automatic cyc(input logic rs, input logic s, input logic r, input logic [31:0] e,
                       input logic b, input logic [31:0] t);
        @(negedge clk);
        rst = rs; if_id_stall = s; if_id_refresh = r; exc_pc = e;
        id_br_taken = b; id_br_target = t;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic hold();
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        // Reset: outputs cleared, no SRAM request.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            check("rst_en", 32'(inst_sram_en), 32'h0);
        end
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_id_inst", id_inst, 32'h0);
        check("rst_id_adel", 32'(id_adel), 32'h0);

        // Reset release: sequential addresses, first instruction two cycles later.
        push_bubble(); push_pc(RST_PC); push_pc(RST_PC + 4); push_pc(RST_PC + 8);
        run(1);
        check("rel_en", 32'(inst_sram_en), 32'h1);
        check("rel_addr0", inst_sram_addr, RST_PC);
        run(1);
        check("rel_addr1", inst_sram_addr, RST_PC + 4);
        run(1);
        check("rel_addr2", inst_sram_addr, RST_PC + 8);
        run(1);

        // Stall for 3 cycles; the word captured in the first stall cycle must survive garbage.
        push_pc(RST_PC + 12); push_pc(RST_PC + 16);
        for (int i = 0; i < 3; i++) begin
            hold();
            check("stall_en", 32'(inst_sram_en), 32'h0);
        end
        run(2);
        hold();

        // Refresh while stalled to 0x100, then taken branch to 0x200 with delay slot 0x104.
        push_bubble(); push_pc(32'h100); push_pc(32'h104); push_pc(32'h200);
        cyc(1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0);
        check("ref_en", 32'(inst_sram_en), 32'h1);
        check("ref_addr", inst_sram_addr, 32'h100);
        run(1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200);
        check("br_addr", inst_sram_addr, 32'h200);
        run(1);
        hold();

        // Branch presented during a stall: redirect only once the stall drops.
        push_bubble(); push_pc(32'h300); push_pc(32'h304); push_pc(32'h400);
        cyc(1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0);
        run(1);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h400);
            check("brstall_en", 32'(inst_sram_en), 32'h0);
        end
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h400);
        check("brstall_addr", inst_sram_addr, 32'h400);
        run(1);
        hold();

        // Refresh during a stall with a loaded buffer: bubble, buffer dropped, then the handler.
        push_bubble(); push_pc(EXC_PC); push_pc(EXC_PC + 4);
        hold();
        cyc(1'b0, 1'b1, 1'b1, EXC_PC, 1'b0, 32'h0);
        check("exc_en", 32'(inst_sram_en), 32'h1);
        check("exc_addr", inst_sram_addr, EXC_PC);
        run(2);
        hold();

        // Jump to a misaligned target: address error with nop travels down.
        push_bubble(); push_pc(32'h500); push_pc(32'h504); push_pc(32'h202); push_pc(32'h206);
        cyc(1'b0, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0);
        run(1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h202);
        check("adel_addr", inst_sram_addr, 32'h202);
        run(2);
        hold();

        // PC increment wraps modulo 2^32.
        push_bubble(); push_pc(32'hFFFF_FFFC); push_pc(32'h0);
        cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        run(2);
        hold();

        // Reset mid-operation beats stall/refresh/branch and discards the buffer.
        cyc(1'b1, 1'b1, 1'b1, 32'h700, 1'b1, 32'h800);
        check("mid_rst_en", 32'(inst_sram_en), 32'h0);
        push_bubble(); push_pc(RST_PC); push_pc(RST_PC + 4);
        run(1);
        check("mid_rst_id_pc", id_pc, 32'h0);
        check("mid_rst_addr", inst_sram_addr, RST_PC);
        run(2);
        hold();
        hold();

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
